mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one external memory bus between the pipeline's instruction-fetch port and data (MEM-stage) port.
//  Runs one transaction at a time with a req/ack handshake on the bus side.
//  Alternates priority between the two ports when both request, and aborts a hung bus via a watchdog.
//  Sits between the pc_reg/if stage, the mem stage and the memory system; its ready outputs drive pipeline stalls.
// PARAMETERS
//  ADDR_WIDTH      32   width of address on all ports
//  DATA_WIDTH      32   width of read/write data on all ports
//  TIMEOUT_CYCLES  255  bus cycles without bus_ack before abort (1..65535)
// PORTS
//  clock            in   1           system clock, rising edge
//  reset            in   1           asynchronous, active-low reset
//  if_request       in   1           fetch request, level, held until if_ready
//  if_addr          in   ADDR_WIDTH  fetch address
//  if_rdata         out  DATA_WIDTH  fetched word, valid only while if_ready=1
//  if_ready         out  1           one-cycle pulse: fetch complete
//  data_request     in   1           data request, level, held until data_ready
//  data_write       in   1           1=store, 0=load
//  data_addr        in   ADDR_WIDTH  data address
//  data_wdata       in   DATA_WIDTH  store data
//  data_byte_select in   4           store byte enables
//  data_rdata       out  DATA_WIDTH  load data, valid only while data_ready=1
//  data_ready       out  1           one-cycle pulse: data access complete
//  bus_request      out  1           bus transaction active
//  bus_write        out  1           bus direction, 1=write
//  bus_addr         out  ADDR_WIDTH  bus address
//  bus_wdata        out  DATA_WIDTH  bus write data
//  bus_byte_select  out  4           bus byte enables; 4'b1111 for fetch and load
//  bus_rdata        in   DATA_WIDTH  bus read data, sampled when bus_ack=1
//  bus_ack          in   1           memory completes the current transaction
//  bus_error        out  1           sticky flag: a watchdog abort has occurred
// BEHAVIOUR
//  - Reset (reset=0, async):
//    - state=IDLE, last_grant=IF; all outputs 0, including bus_error and both rdata outputs.
//    - An in-flight transaction is abandoned and no ready pulse is issued.
//  - FSM states: IDLE, BUSY_IF, BUSY_DATA, DONE.
//  - IDLE:
//    - Only data_request -> BUSY_DATA. Only if_request -> BUSY_IF.
//    - Both -> the port not named by last_grant (first conflict after reset goes to data).
//    - Neither -> stay in IDLE.
//  - On entry to BUSY_*: register bus_addr, bus_write, bus_wdata and bus_byte_select from the granted port, and set bus_request=1.
//    - Bus fields stay stable for the whole transaction.
//    - last_grant <= granted port. Watchdog counter <= 0.
//  - BUSY_*:
//    - bus_ack=1 -> capture bus_rdata into the granted port's rdata register; bus_request <= 0; go to DONE.
//    - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no ack: abort.
//      Abort means rdata <= 0, bus_request <= 0, bus_error <= 1, go to DONE.
//  - DONE (exactly 1 cycle):
//    - Granted port's ready=1; the other ready=0. Then go to IDLE.
//    - A turnaround cycle always follows, so there are no back-to-back grants.
//  - Latency (request held from cycle 0, bus_ack in cycle k >= 1):
//    - bus_request is high in cycles 1..k; ready pulses in cycle k+1.
//    - Minimum is request to ready = 2 cycles, plus 1 IDLE cycle before the next grant.
//  - Stores: data_rdata in the DONE cycle equals the captured bus_rdata; the requester ignores it.
//  - Requester drops its request mid-transaction: the transaction still completes and ready still pulses.
//  - bus_ack while in IDLE or DONE is ignored. Requests are not sampled outside IDLE.
//  - rdata registers hold their value outside ready pulses; only the ready-cycle value is contractual.
//  - bus_error clears only on reset.
//  - Counter width is 16 bits. It saturates and never wraps.
// STRUCTURE
//  - utility.v gains: arbiter state encodings (ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_DATA, ARB_DONE), grant IDs (GRANT_IF, GRANT_DATA), ARB_STATE_BUS.
//  - One sub-module, bus_watchdog: clear/enable inputs, parameter TIMEOUT_CYCLES, expired output.
//  - The FSM, capture registers and muxing stay in mem_bus_arbiter.
// TESTING
//  - Reset release with no requests -> all outputs 0 for 10 cycles; bus_ack pulses in IDLE are ignored.
//  - if_request=1, if_addr=0x0000_0040, bus_ack in cycle 3 with 0x2402_0005:
//    - bus_addr=0x40 and bus_byte_select=4'hF in cycles 1-3.
//    - if_ready=1 and if_rdata=0x2402_0005 in cycle 4.
//  - Both ports request continuously, ack 1 cycle after each grant:
//    - Grants alternate DATA, IF, DATA, IF.
//    - One ready pulse every 3 cycles.
//  - data_write=1, data_addr=0x100, data_wdata=0xDEAD_BEEF, data_byte_select=4'b0011:
//    - bus_write=1 and bus fields stable until ack.
//    - data_ready pulses once; if_ready stays 0.
//  - Never ack, TIMEOUT_CYCLES=8:
//    - bus_request high for cycles 1-8.
//    - Cycle 9: ready pulse with rdata=0, and bus_error=1 remains set.
//  - reset asserted in cycle 2 of a BUSY_DATA:
//    - Outputs 0 immediately, no data_ready.
//    - After release a simultaneous request is granted to data.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
// State and grant encodings plus the watchdog counter width.
package mem_bus_arbiter_pkg;

  localparam int unsigned ArbStateBus   = 2;
  localparam int unsigned WatchdogWidth = 16;

  typedef enum logic [ArbStateBus-1:0] {
    ArbIdle     = 2'd0,
    ArbBusyIf   = 2'd1,
    ArbBusyData = 2'd2,
    ArbDone     = 2'd3
  } arb_state_e;

  typedef enum logic {
    GrantIf   = 1'b0,
    GrantData = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Saturating cycle counter that flags a bus transaction waiting too long for bus_ack.
// expired is combinational so the FSM can abort in the same cycle the limit is reached.
module mem_bus_arbiter_bus_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WatchdogWidth-1:0] LastCount = WatchdogWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [WatchdogWidth-1:0] MaxCount  = '1;

  logic [WatchdogWidth-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != MaxCount) begin
      count <= count + WatchdogWidth'(1);
    end
  end

  assign expired = (count >= LastCount);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch port and the data port, one transaction at a time,
// alternating priority on conflicts and aborting hung transactions via a watchdog.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_request,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  data_request,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  input  logic [3:0]            data_byte_select,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_ready,
  output logic                  bus_request,
  output logic                  bus_write,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_byte_select,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_error
);

  arb_state_e state;
  grant_e     last_grant;
  logic       busy;
  logic       expired;

  assign busy = (state == ArbBusyIf) || (state == ArbBusyData);

  mem_bus_arbiter_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (!busy),
    .enable (busy),
    .expired(expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= ArbIdle;
      last_grant      <= GrantIf;
      if_rdata        <= '0;
      if_ready        <= 1'b0;
      data_rdata      <= '0;
      data_ready      <= 1'b0;
      bus_request     <= 1'b0;
      bus_write       <= 1'b0;
      bus_addr        <= '0;
      bus_wdata       <= '0;
      bus_byte_select <= 4'h0;
      bus_error       <= 1'b0;
    end else begin
      if_ready   <= 1'b0;
      data_ready <= 1'b0;
      unique case (state)
        ArbIdle: begin
          // On a conflict the port that did not win last time goes first.
          if (data_request && (!if_request || last_grant == GrantIf)) begin
            state           <= ArbBusyData;
            last_grant      <= GrantData;
            bus_request     <= 1'b1;
            bus_write       <= data_write;
            bus_addr        <= data_addr;
            bus_wdata       <= data_wdata;
            bus_byte_select <= data_write ? data_byte_select : 4'hF;
          end else if (if_request) begin
            state           <= ArbBusyIf;
            last_grant      <= GrantIf;
            bus_request     <= 1'b1;
            bus_write       <= 1'b0;
            bus_addr        <= if_addr;
            bus_wdata       <= '0;
            bus_byte_select <= 4'hF;
          end
        end
        ArbBusyIf, ArbBusyData: begin
          // An ack in the final watchdog cycle still wins over the abort.
          if (bus_ack || expired) begin
            state       <= ArbDone;
            bus_request <= 1'b0;
            if (!bus_ack) begin
              bus_error <= 1'b1;
            end
            if (state == ArbBusyIf) begin
              if_ready <= 1'b1;
              if_rdata <= bus_ack ? bus_rdata : '0;
            end else begin
              data_ready <= 1'b1;
              data_rdata <= bus_ack ? bus_rdata : '0;
            end
          end
        end
        ArbDone: begin
          state <= ArbIdle;
        end
        default: begin
          state <= ArbIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int          TO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          if_request = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          data_request = 1'b0;
  logic          data_write = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [3:0]    data_byte_select = 4'h0;
  logic [DW-1:0] data_rdata;
  logic          data_ready;
  logic          bus_request;
  logic          bus_write;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [3:0]    bus_byte_select;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;
  logic          bus_error;

  int checks = 0;
  int errors = 0;
  bit model_last_data = 1'b0;  // 1 when the data port won the most recent grant
  bit model_err = 1'b0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .if_request      (if_request),
    .if_addr         (if_addr),
    .if_rdata        (if_rdata),
    .if_ready        (if_ready),
    .data_request    (data_request),
    .data_write      (data_write),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_byte_select(data_byte_select),
    .data_rdata      (data_rdata),
    .data_ready      (data_ready),
    .bus_request     (bus_request),
    .bus_write       (bus_write),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_byte_select (bus_byte_select),
    .bus_rdata       (bus_rdata),
    .bus_ack         (bus_ack),
    .bus_error       (bus_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {bus_request, bus_write, bus_error, if_ready, data_ready, bus_byte_select},
          64'h0);
    check({tag, "_addr"}, bus_addr, 64'h0);
    check({tag, "_wdata"}, bus_wdata, 64'h0);
    check({tag, "_rdata"}, {if_rdata, data_rdata}, 64'h0);
  endtask

  // Caller is just after a negedge with the DUT idle. ack_at is the busy cycle (1-based) in
  // which bus_ack is driven; any value outside 1..TO means the memory never answers.
  task automatic run_txn(input bit req_if, input bit req_d, input logic [AW-1:0] ia,
                         input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                         input logic [3:0] dbs, input int ack_at, input logic [DW-1:0] rd,
                         input bit drop);
    bit            g_data;
    bit            done;
    int            k;
    logic [AW-1:0] e_addr;
    logic [3:0]    e_bs;
    logic [DW-1:0] e_rd;
    if_request       = req_if;
    if_addr          = ia;
    data_request     = req_d;
    data_write       = dw;
    data_addr        = da;
    data_wdata       = dwd;
    data_byte_select = dbs;
    g_data = req_d && (!req_if || !model_last_data);
    model_last_data = g_data;
    e_addr = g_data ? da : ia;
    e_bs   = (g_data && dw) ? dbs : 4'hF;
    e_rd   = '0;
    done   = 1'b0;
    k      = 0;
    while (!done) begin
      @(negedge clock);
      k++;
      check("busy_req", bus_request, 1'b1);
      check("busy_addr", bus_addr, e_addr);
      check("busy_write", bus_write, g_data & dw);
      check("busy_bs", bus_byte_select, e_bs);
      if (g_data) check("busy_wdata", bus_wdata, dwd);
      check("busy_ready", {if_ready, data_ready}, 2'b00);
      check("busy_err", bus_error, model_err);
      if (drop && k == 1) begin
        if_request   = 1'b0;
        data_request = 1'b0;
      end
      if (k == ack_at) begin
        bus_ack   = 1'b1;
        bus_rdata = rd;
        e_rd      = rd;
        done      = 1'b1;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        if (k == TO) begin
          done      = 1'b1;
          model_err = 1'b1;
        end
      end
    end
    @(negedge clock);
    bus_ack = 1'b0;
    check("done_req", bus_request, 1'b0);
    check("done_ready", {if_ready, data_ready}, {!g_data, g_data});
    check("done_rdata", g_data ? data_rdata : if_rdata, e_rd);
    check("done_err", bus_error, model_err);
    if_request   = 1'b0;
    data_request = 1'b0;
    @(negedge clock);
    check("idle_req", bus_request, 1'b0);
    check("idle_ready", {if_ready, data_ready}, 2'b00);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #1 check_all_zero("in_reset");
    reset = 1'b1;

    // Stray acks while idle must be ignored.
    for (int i = 0; i < 10; i++) begin
      bus_ack   = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      @(negedge clock);
      check_all_zero("idle_after_reset");
    end
    bus_ack = 1'b0;

    run_txn(1, 0, 32'h0000_0040, 0, 0, 0, 0, 3, 32'h2402_0005, 0);

    // Both ports held: grants alternate DATA, IF, DATA, IF with ack in the first busy cycle.
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 1, 32'h1000 + 32'(i), 0, 32'h2000 + 32'(i), 32'h5555_0000 + 32'(i), 4'h3, 1,
              $urandom, 0);
    end

    run_txn(0, 1, 0, 1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 4, 32'h1234_5678, 0);

    // Never acked: abort after TO busy cycles, error becomes sticky.
    run_txn(0, 1, 0, 0, 32'h300, 0, 0, 0, 32'hFFFF_FFFF, 0);
    run_txn(1, 0, 32'h44, 0, 0, 0, 0, 2, 32'hCAFE_0001, 1);

    for (int i = 0; i < 150; i++) begin
      bit ri;
      bit rdq;
      ri  = 1'($urandom_range(0, 1));
      rdq = ri ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(ri, rdq, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
              4'($urandom_range(0, 15)), int'($urandom_range(0, TO + 1)), $urandom,
              1'($urandom_range(0, 1)));
    end

    // Reset in the second busy cycle of a data access.
    data_request = 1'b1;
    data_write   = 1'b0;
    data_addr    = 32'h0000_0800;
    @(negedge clock);
    check("pre_reset_req", bus_request, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    #1 check_all_zero("async_reset");
    data_request = 1'b0;
    bus_ack      = 1'b1;
    @(negedge clock);
    check("reset_no_ready", {data_ready, if_ready}, 2'b00);
    bus_ack         = 1'b0;
    reset           = 1'b1;
    model_last_data = 1'b0;
    model_err       = 1'b0;
    run_txn(1, 1, 32'h60, 0, 32'h64, 0, 0, 1, 32'h0BAD_F00D, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
